// File: rtl/ucdp_sync_filt.sv
// Multi-channel input synchronizer with optional debounce filter, edge detection
// and sticky edge flags with per-channel synchronous clear.
module ucdp_sync_filt #(
    parameter int unsigned        width_p       = 1,
    parameter int unsigned        stages_p      = 2,
    parameter int unsigned        filt_p        = 0,
    parameter logic [1:0]         edge_type_p   = 2'h0,
    parameter logic [width_p-1:0] rstval_p      = '0,
    parameter bit                 norstvalchk_p = 1'b0
) (
    input  logic               main_clk_i,
    input  logic               main_rst_an_i,
    input  logic [width_p-1:0] d_i,
    output logic [width_p-1:0] q_o,
    output logic [width_p-1:0] edge_o,
    output logic [width_p-1:0] edge_sticky_o,
    input  logic [width_p-1:0] edge_clr_i
);

    localparam int unsigned cnt_w = (filt_p > 0) ? $clog2(filt_p + 1) : 1;

    if (stages_p < 2 || stages_p > 4) begin : g_bad_stages
        $error("ucdp_sync_filt: stages_p must be in 2..4");
    end
    if (width_p < 1 || width_p > 32) begin : g_bad_width
        $error("ucdp_sync_filt: width_p must be in 1..32");
    end
    if (filt_p > 255) begin : g_bad_filt
        $error("ucdp_sync_filt: filt_p must be in 0..255");
    end

    logic [stages_p-1:0][width_p-1:0] sync_q;
    logic [width_p-1:0]               sync_s;
    logic [width_p-1:0]               filt;
    logic [width_p-1:0]               hist_q;
    logic [width_p-1:0]               edge_det;
    logic [width_p-1:0]               sticky_q;

    // Synchronizer chain, index 0 is the first (metastable) stage
    always_ff @(posedge main_clk_i or negedge main_rst_an_i) begin
        if (!main_rst_an_i) begin
            sync_q <= {stages_p{rstval_p}};
        end else begin
            sync_q <= {sync_q[stages_p-2:0], d_i};
        end
    end

    assign sync_s = sync_q[stages_p-1];

    if (filt_p == 0) begin : g_nofilt
        assign filt = sync_s;
    end else begin : g_filt
        for (genvar i = 0; i < int'(width_p); i++) begin : g_ch
            logic [cnt_w-1:0] cnt_q;
            logic             f_q;

            // Filtered level follows s only after filt_p consecutive differing samples
            always_ff @(posedge main_clk_i or negedge main_rst_an_i) begin
                if (!main_rst_an_i) begin
                    cnt_q <= '0;
                    f_q   <= rstval_p[i];
                end else if (sync_s[i] == f_q) begin
                    cnt_q <= '0;
                end else if (cnt_q == cnt_w'(filt_p - 1)) begin
                    f_q   <= sync_s[i];
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_q + cnt_w'(1);
                end
            end

            assign filt[i] = f_q;
        end
    end

    // History and sticky flags; history resets to rstval_p so release makes no edge
    always_ff @(posedge main_clk_i or negedge main_rst_an_i) begin
        if (!main_rst_an_i) begin
            hist_q   <= rstval_p;
            sticky_q <= '0;
        end else begin
            hist_q   <= filt;
            sticky_q <= (sticky_q & ~edge_clr_i) | edge_det;
        end
    end

    always_comb begin
        edge_det = '0;
        case (edge_type_p)
            2'd1:    edge_det = ~hist_q & filt;
            2'd2:    edge_det = hist_q & ~filt;
            2'd3:    edge_det = hist_q ^ filt;
            default: edge_det = '0;
        endcase
    end

    assign q_o           = filt;
    assign edge_o        = edge_det;
    assign edge_sticky_o = sticky_q;

    if (!norstvalchk_p) begin : g_rstchk
`ifdef SIM
        bit warned;
        always @(posedge main_rst_an_i) begin
            if (!warned && (d_i != rstval_p)) begin
                warned <= 1'b1;
                $warning("%m: d_i differs from rstval_p at reset release, mask %b",
                         d_i ^ rstval_p);
            end
        end
`endif
    end

endmodule
